// File: rtl/loopyV_data_types.sv
// Shared types for the MEM/WB stage: write-back select, load funct3, FSM state, held bundle.
// LOOPYV_RVC_LINK_EN adds the compressed flag to the held bundle.
package loopyV_data_types;

  localparam int MW_XLEN = 32;
  localparam int MW_RA_W = 5;
  localparam int MW_PC_W = 32;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_IMM  = 2'd1,
    WB_SEL_LOAD = 2'd2,
    WB_SEL_PC4  = 2'd3
  } WbSelType;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    MW_EMPTY,
    MW_FULL,
    MW_WAIT_LOAD,
    MW_DRAIN
  } MemWbStateType;

  typedef struct packed {
    logic [MW_RA_W-1:0] rdAddr;
    logic               rdWriteEn;
    WbSelType           destSel;
    logic [MW_XLEN-1:0] result;
    logic [MW_PC_W-1:0] pc;
    logic [2:0]         funct3;
    logic [1:0]         addrLsb;
`ifdef LOOPYV_RVC_LINK_EN
    logic               isCompressed;
`endif
  } MemWbType;

endpackage

// File: rtl/pipe_mem_wb_stage_if.sv
// MEM->WB handshake, data-memory response and write-back port bundle.
// slave: the stage; master: the driver. LOOPYV_RVC_LINK_EN adds memIsCompressed.
interface pipe_mem_wb_stage_if
  import loopyV_data_types::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int PC_W = 32
);
  logic            memValid;
  logic            memReady;
  logic [RA_W-1:0] memRdAddr;
  logic            memRdWriteEn;
  WbSelType        memDestSel;
  logic [XLEN-1:0] memResult;
  logic [PC_W-1:0] memPc;
  logic [2:0]      memLoadFunct3;
  logic [1:0]      memAddrLsb;
`ifdef LOOPYV_RVC_LINK_EN
  logic            memIsCompressed;
`endif
  logic            dmRespValid;
  logic [XLEN-1:0] dmRespData;
  logic            flush;
  logic            wbValid;
  logic [RA_W-1:0] wbRdAddr;
  logic            wbRdWriteEn;
  logic [XLEN-1:0] wbRdWriteData;
  logic [PC_W-1:0] wbPc;

  modport slave (
`ifdef LOOPYV_RVC_LINK_EN
    input  memIsCompressed,
`endif
    input  memValid, memRdAddr, memRdWriteEn,
    input  memDestSel, memResult, memPc,
    input  memLoadFunct3, memAddrLsb,
    input  dmRespValid, dmRespData, flush,
    output memReady, wbValid, wbRdAddr,
    output wbRdWriteEn, wbRdWriteData, wbPc
  );

  modport master (
`ifdef LOOPYV_RVC_LINK_EN
    output memIsCompressed,
`endif
    output memValid, memRdAddr, memRdWriteEn,
    output memDestSel, memResult, memPc,
    output memLoadFunct3, memAddrLsb,
    output dmRespValid, dmRespData, flush,
    input  memReady, wbValid, wbRdAddr,
    input  wbRdWriteEn, wbRdWriteData, wbPc
  );
endinterface

// File: rtl/load_align.sv
// Combinational load formatter: lane select plus sign/zero extension.
// Ports: raw word, funct3, lsb in; formatted XLEN word out.
module load_align
  import loopyV_data_types::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      funct3,
  input  logic [1:0]      lsb,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = raw[7:0];
    unique case (lsb)
      2'd0: b = raw[7:0];
      2'd1: b = raw[15:8];
      2'd2: b = raw[23:16];
      2'd3: b = raw[31:24];
    endcase
    // lsb[0] is ignored: misaligned halves trap upstream
    h = lsb[1] ? raw[31:16] : raw[15:0];
    data = raw;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){b[7]}}, b};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
      F3_LH:   data = {{(XLEN-16){h[15]}}, h};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
      F3_LW:   data = raw;
      default: data = raw;
    endcase
  end
endmodule

// File: rtl/pipe_mem_wb_stage.sv
// MEM/WB stage: registers results, waits on load responses, formats load data.
// Ports: clk, arst, bus (slave). LOOPYV_RVC_LINK_EN selects pc+2 links.
module pipe_mem_wb_stage
  import loopyV_data_types::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int PC_W = 32
) (
  input logic clk,
  input logic arst,
  pipe_mem_wb_stage_if.slave bus
);
  MemWbStateType   state;
  MemWbType        held;
  logic            accept;
  logic            isLoad;
  logic [XLEN-1:0] ldData;
  logic [XLEN-1:0] link;

  always_comb begin
    bus.memReady = 1'b0;
    unique case (state)
      MW_EMPTY:     bus.memReady = 1'b1;
      MW_FULL:      bus.memReady = 1'b1;
      MW_WAIT_LOAD: bus.memReady = bus.dmRespValid;
      MW_DRAIN:     bus.memReady = 1'b0;
    endcase
    if (bus.flush) bus.memReady = 1'b0;
  end

  assign accept = bus.memValid && bus.memReady;
  assign isLoad = bus.memDestSel == WB_SEL_LOAD;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state <= MW_EMPTY;
      held  <= '0;
    end else if (bus.flush && state == MW_WAIT_LOAD
                 && !bus.dmRespValid) begin
      // keep tracking the request so its reply is dropped
      state <= MW_DRAIN;
    end else if (bus.flush) begin
      state <= MW_EMPTY;
    end else if (accept) begin
      state          <= isLoad ? MW_WAIT_LOAD : MW_FULL;
      held.rdAddr    <= bus.memRdAddr;
      held.rdWriteEn <= bus.memRdWriteEn;
      held.destSel   <= bus.memDestSel;
      held.result    <= bus.memResult;
      held.pc        <= bus.memPc;
      held.funct3    <= bus.memLoadFunct3;
      held.addrLsb   <= bus.memAddrLsb;
`ifdef LOOPYV_RVC_LINK_EN
      held.isCompressed <= bus.memIsCompressed;
`endif
    end else if (state == MW_FULL) begin
      state <= MW_EMPTY;
    end else if (state != MW_EMPTY && bus.dmRespValid) begin
      state <= MW_EMPTY;
    end
  end

  load_align #(.XLEN(XLEN)) u_align (
    .raw    (bus.dmRespData),
    .funct3 (held.funct3),
    .lsb    (held.addrLsb),
    .data   (ldData)
  );

`ifdef LOOPYV_RVC_LINK_EN
  assign link = XLEN'(held.pc)
              + (held.isCompressed ? XLEN'(2) : XLEN'(4));
`else
  assign link = XLEN'(held.pc) + XLEN'(4);
`endif

  always_comb begin
    bus.wbRdWriteData = held.result;
    unique case (held.destSel)
      WB_SEL_ALU:  bus.wbRdWriteData = held.result;
      WB_SEL_IMM:  bus.wbRdWriteData = held.result;
      WB_SEL_LOAD: bus.wbRdWriteData = ldData;
      WB_SEL_PC4:  bus.wbRdWriteData = link;
    endcase
  end

  assign bus.wbValid = !bus.flush
    && (state == MW_FULL
        || (state == MW_WAIT_LOAD && bus.dmRespValid));
  assign bus.wbRdWriteEn = bus.wbValid && held.rdWriteEn
                         && (held.rdAddr != '0);
  assign bus.wbRdAddr = held.rdAddr;
  assign bus.wbPc     = held.pc;
endmodule

// File: doc/pipe_mem_wb_stage.md
Name: pipe_mem_wb_stage

Overview:
- Parametrised MEM/WB pipeline stage with valid/ready handshake toward MEM and a variable-latency data-memory response.
- Registers ALU/immediate/link results and formats load data (byte/half/word, signed/unsigned, lane select).
- Backpressures MEM while a load is outstanding, and supports flush with discard of an in-flight load response.
- Sits between the memory-access stage and the register-file write port.

Parameters:
- XLEN, 32, datapath and register width.
- RA_W, 5, register address width.
- PC_W, 32, program counter width.

Ports:
- clk  in  1  clock, rising edge.
- arst  in  1  asynchronous reset, active-high.
- memValid  in  1  MEM stage offers an instruction.
- memReady  out  1  stage accepts the instruction this cycle.
- memRdAddr  in  RA_W  destination register.
- memRdWriteEn  in  1  destination write enable.
- memDestSel  in  2  WbSelType: ALU=0, IMM=1, LOAD=2, PC4=3.
- memResult  in  XLEN  ALU or immediate result.
- memPc  in  PC_W  instruction PC.
- memLoadFunct3  in  3  load type.
- memAddrLsb  in  2  load byte address bits [1:0].
- dmRespValid  in  1  load data valid.
- dmRespData  in  XLEN  raw memory word.
- flush  in  1  kill the held or pending instruction.
- wbValid  out  1  write-back beat valid.
- wbRdAddr  out  RA_W  destination register.
- wbRdWriteEn  out  1  register-file write strobe.
- wbRdWriteData  out  XLEN  write data.
- wbPc  out  PC_W  retiring PC.

Behaviour:
- States: EMPTY, FULL, WAIT_LOAD, DRAIN.
- Accept means memValid && memReady.
- memReady:
  - EMPTY or FULL: 1.
  - WAIT_LOAD: equals dmRespValid.
  - DRAIN: 0.
  - Forced 0 whenever flush is 1.
- Write-back never stalls. FULL lasts one cycle unless a new accept occurs.
- Transitions, evaluated in this order:
  - flush && state==WAIT_LOAD && !dmRespValid -> DRAIN.
  - Otherwise, flush -> EMPTY.
  - Accept of non-load -> FULL.
  - Accept of load -> WAIT_LOAD.
  - No accept: FULL -> EMPTY; WAIT_LOAD && dmRespValid -> EMPTY.
  - DRAIN && dmRespValid -> EMPTY; the response is discarded.
- Non-load latency: 1 cycle. The result is registered, and wbValid=1 in the cycle after accept.
- Load latency:
  - The earliest response is the cycle after accept.
  - In WAIT_LOAD with dmRespValid=1, wbValid=1 in that same cycle, with combinationally formatted dmRespData.
  - dmRespValid is ignored in EMPTY and FULL.
- Back-to-back loads are allowed: the response cycle may accept the next instruction.
- wbValid is 1 only in FULL, or in WAIT_LOAD && dmRespValid. It is 0 in a flush cycle.
- wbRdWriteEn = wbValid && rdWriteEn && (rdAddr != 0).
- Write data by destination select:
  - ALU and IMM: registered memResult.
  - PC4: pc + 4, truncated to XLEN.
  - LOAD: formatted load data.
- Load formatting:
  - LB (000) and LBU (100): byte lane = addrLsb.
  - LH (001) and LHU (101): half lane = addrLsb[1]; addrLsb[0] is ignored, because misalignment traps upstream.
  - LW (010): raw word.
  - Other funct3 values: raw word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Reset, while arst is high:
  - State is EMPTY.
  - Held fields are cleared, and destSel = ALU.
  - All outputs are 0 and memReady = 1.
- Reset mid-load abandons the request; no response tracking survives reset.

Optional Feature:
- Macro: LOOPYV_RVC_LINK_EN.
- When defined:
  - Adds input port memIsCompressed (1 bit), registered with the instruction.
  - PC4 select writes pc+2 when the registered memIsCompressed is 1, and pc+4 otherwise.
- When undefined: the port is absent, and the link value is always pc+4.

Decomposition:
- Shared package loopyV_data_types gains:
  - WbSelType enum, including WB_SEL_PC4.
  - LoadFunct3 constants: LB, LH, LW, LBU, LHU.
  - MemWbStateType enum.
  - MEMWB pipeline struct, parametrised through XLEN-width fields.
- One sub-module, load_align: purely combinational. Inputs are raw word, funct3 and lsb; output is the formatted XLEN word. It is reused by future load/store units.

Test Plan:
- ALU path: accept memDestSel=ALU, memResult=0x1234_5678, memRdAddr=5 -> next cycle wbValid=1, wbRdWriteEn=1, wbRdWriteData=0x1234_5678; the following cycle wbValid=0.
- Load byte: LB with memAddrLsb=3, response 3 cycles later with dmRespData=0x80AA_BBCC -> memReady=0 for 2 cycles; in the response cycle wbRdWriteData=0xFFFF_FF80 and wbValid=1. Repeat with LHU, lsb=2 -> 0x0000_80AA.
- Back-to-back: load then ALU op presented in the response cycle -> both retire on consecutive cycles with no bubble.
- Flush while WAIT_LOAD, response arriving 2 cycles later -> DRAIN; memReady=0 until the response; response discarded; no wbValid pulse.
- x0 and link: PC4 with memPc=0x100, memRdAddr=0 -> wbValid=1, wbRdWriteEn=0. With memRdAddr=1 -> data 0x104, or 0x102 when LOOPYV_RVC_LINK_EN is defined and memIsCompressed=1.
- Async reset asserted mid-WAIT_LOAD -> outputs 0 immediately and memReady=1; after release, a stale dmRespValid is ignored in EMPTY.
